// File: rtl/ser_pattern_ctrl.sv
// Drives a WIDTH-bit pattern LSB-first into a pattern detector passes+1 times,
// waits DRAIN_CYC cycles for detector latency, and counts the match pulses seen.
module ser_pattern_ctrl #(
  parameter int WIDTH     = 10,
  parameter int CNT_W     = 6,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       passes,
  output logic             ser_out,
  input  logic             det_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [3:0]         pass_cnt_q;
  logic [3:0]         passes_q;
  logic [3:0]         drain_cnt_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic               ser_out_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   shreg_d;

  // After WIDTH rotations the register holds the original pattern again,
  // so back-to-back passes need no reload.
  assign shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};

  // NOTE: every state register is assigned with <= so all updates use the
  // values from before the edge; a later assignment in the block overrides an
  // earlier one, which is how start clears the hit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      pass_cnt_q  <= '0;
      passes_q    <= '0;
      drain_cnt_q <= '0;
      hit_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Counted even on an aborting edge, since busy is still high in that cycle.
      if (busy_q && det_in && (hit_cnt_q != {CNT_W{1'b1}})) begin
        hit_cnt_q <= hit_cnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q    <= pattern;
            passes_q   <= passes;
            bit_cnt_q  <= '0;
            pass_cnt_q <= '0;
            hit_cnt_q  <= '0;
            ser_out_q  <= pattern[0];
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            ser_out_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            shreg_q <= shreg_d;
            if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
              if (pass_cnt_q < passes_q) begin
                bit_cnt_q  <= '0;
                pass_cnt_q <= pass_cnt_q + 4'd1;
                ser_out_q  <= shreg_d[0];
              end else begin
                drain_cnt_q <= '0;
                ser_out_q   <= 1'b0;
                state_q     <= DRAIN;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              ser_out_q <= shreg_d[0];
            end
          end
        end

        DRAIN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (drain_cnt_q == 4'(DRAIN_CYC - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q + 4'd1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          ser_out_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ser_out   = ser_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit_count = hit_cnt_q;

endmodule

// File: tb/tb_ser_pattern_ctrl.sv
// Directed bench for ser_pattern_ctrl: single pass, repetition, saturation,
// abort, start-while-busy and reset mid-run, all with hand-derived timing.
module tb_ser_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [9:0] pattern;
  logic [3:0] passes;
  logic       ser_out;
  logic       det_in;
  logic       busy;
  logic       done;
  logic [5:0] hit_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  ser_pattern_ctrl #(.WIDTH(10), .CNT_W(6), .DRAIN_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .passes    (passes),
    .ser_out   (ser_out),
    .det_in    (det_in),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge, mid-cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Start is sampled at edge 0; returns in the middle of cycle 1.
  task automatic begin_run(input logic [9:0] pat, input logic [3:0] ps);
    pattern = pat;
    passes  = ps;
    start   = 1'b1;
    cyc     = 0;
    tick();
    start = 1'b0;
  endtask

  // Expects to be called in cycle 1 of a run of 10'b0010101010, passes=0.
  task automatic check_single(input string pfx);
    int exp_ser[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    for (int c = 1; c <= 14; c++) begin
      check($sformatf("%s_ser_c%0d", pfx, c), ser_out, (c <= 10) ? exp_ser[c-1] : 0);
      check($sformatf("%s_busy_c%0d", pfx, c), busy, (c <= 12) ? 1 : 0);
      check($sformatf("%s_done_c%0d", pfx, c), done, (c == 13) ? 1 : 0);
      if (c < 14) tick();
    end
    check({pfx, "_hits"}, hit_count, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = done;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    abort   = 1'b0;
    det_in  = 1'b1;
    pattern = 10'b0010101010;
    passes  = 4'd0;

    // Reset held with start and det_in high: nothing may leave reset state.
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ser", ser_out, 0);
    check("rst_hits", hit_count, 0);

    // Single pass: start accepted on the first edge with rst low.
    rst    = 1'b0;
    det_in = 1'b0;
    begin_run(10'b0010101010, 4'd0);
    check_single("single");

    // Three back-to-back passes; pattern/passes changed mid-run must not matter.
    tick();
    begin
      logic [9:0] p2 = 10'b1100111010;
      begin_run(p2, 4'd2);
      for (int c = 1; c <= 43; c++) begin
        det_in = (c == 5 || c == 17 || c == 31 || c == 36);
        if (c == 3) begin
          pattern = 10'b0000000000;
          passes  = 4'd0;
        end
        if (c <= 30) check($sformatf("rep_ser_c%0d", c), ser_out, p2[(c-1)%10]);
        else if (c <= 35) check($sformatf("rep_ser_c%0d", c), ser_out, 0);
        check($sformatf("rep_busy_c%0d", c), busy, (c <= 32) ? 1 : 0);
        check($sformatf("rep_done_c%0d", c), done, (c == 33) ? 1 : 0);
        if (c == 6)  check("rep_hits_c6", hit_count, 1);
        if (c == 18) check("rep_hits_c18", hit_count, 2);
        if (c == 33) check("rep_hits_done", hit_count, 3);
        if (c == 43) check("rep_hits_hold", hit_count, 3);
        if (c < 43) tick();
      end
      det_in = 1'b0;
    end

    // Saturation: 162 busy cycles with det_in held high.
    tick();
    begin
      int busy_n  = 0;
      int done_at = 0;
      begin_run(10'b1010011001, 4'd15);
      det_in = 1'b1;
      for (int c = 1; c <= 200; c++) begin
        if (busy) busy_n++;
        if (done && done_at == 0) begin
          done_at = c;
          check("sat_hits_done", hit_count, 63);
        end
        if (c == 63) check("sat_hits_c63", hit_count, 62);
        if (c == 64) check("sat_hits_c64", hit_count, 63);
        if (c == 150) check("sat_hits_c150", hit_count, 63);
        tick();
      end
      check("sat_busy_cycles", busy_n, 162);
      check("sat_done_cycle", done_at, 163);
      check("sat_hits_end", hit_count, 63);
      det_in = 1'b0;
    end

    // Abort in SHIFT with a coincident det_in pulse, then an immediate restart.
    tick();
    begin_run(10'h3FF, 4'd1);
    tick();
    tick();
    tick();
    det_in = 1'b1;
    abort  = 1'b1;
    check("abt_ser_c4", ser_out, 1);
    tick();
    det_in = 1'b0;
    abort  = 1'b0;
    check("abt_busy_c5", busy, 0);
    check("abt_ser_c5", ser_out, 0);
    check("abt_done_c5", done, 0);
    check("abt_hits_c5", hit_count, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abt_restart_busy", busy, 1);
    check("abt_restart_hits", hit_count, 0);
    wait_done("abt_restart_done", 40);
    tick();

    // Abort and start together in IDLE: start wins; then abort in SHIFT.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    check("both_busy", busy, 1);
    tick();
    check("both_abort_busy", busy, 0);
    abort = 1'b0;

    // Abort during DRAIN ends the run with no done pulse.
    begin_run(10'b0010101010, 4'd0);
    for (int c = 1; c < 11; c++) tick();
    abort = 1'b1;
    check("drn_busy_c11", busy, 1);
    tick();
    abort = 1'b0;
    check("drn_busy_c12", busy, 0);
    check("drn_done_c12", done, 0);
    tick();
    check("drn_done_c13", done, 0);

    // Start pulsed mid-run is ignored; exactly one done at the original time.
    tick();
    begin
      int done_n  = 0;
      int done_at = 0;
      begin_run(10'b0010101010, 4'd0);
      for (int c = 1; c <= 30; c++) begin
        start = (c == 6);
        if (c == 12) check("sib_busy_c12", busy, 1);
        if (done) begin
          done_n++;
          if (done_at == 0) done_at = c;
        end
        tick();
      end
      start = 1'b0;
      check("sib_done_count", done_n, 1);
      check("sib_done_cycle", done_at, 13);
    end

    // Reset at cycle 8, then a fresh run identical to the single-pass case.
    begin_run(10'b1111100000, 4'd3);
    for (int c = 1; c < 8; c++) begin
      det_in = (c == 3);
      tick();
    end
    det_in = 1'b0;
    check("rmr_hits_c8", hit_count, 1);
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    check("rmr_busy", busy, 0);
    check("rmr_ser", ser_out, 0);
    check("rmr_done", done, 0);
    check("rmr_hits", hit_count, 0);
    begin_run(10'b0010101010, 4'd0);
    check_single("rmr_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_pattern_ctrl.md
SER_PATTERN_CTRL -- requirements
Module: ser_pattern_ctrl

Parameters
REQ-001 SHALL provide WIDTH, default 10, the pattern length in bits.
REQ-002 SHALL provide CNT_W, default 6, the hit-counter width.
REQ-003 SHALL provide DRAIN_CYC, default 2 (range 1..15), the number of post-pattern cycles allowed for detector latency.

Interface
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: terminates a run with no done pulse.
REQ-008 SHALL have port pattern, input, WIDTH bits: serial pattern, transmitted LSB first.
REQ-009 SHALL have port passes, input, 4 bits: extra repetitions, so the pattern is sent passes+1 times.
REQ-010 SHALL have port ser_out, output, 1 bit: serial bit driven to the detector's "in".
REQ-011 SHALL have port det_in, input, 1 bit: the detector's "out", a match pulse.
REQ-012 SHALL have port busy, output, 1 bit: high in SHIFT and DRAIN.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port hit_count, output, CNT_W bits: number of matches in the current or last run.

Function
REQ-015 SHALL implement the FSM states IDLE, SHIFT, DRAIN and DONE, all outputs decoded from registered state.
REQ-016 In IDLE with start=1, SHALL at that edge:
  - load pattern and passes into internal registers;
  - clear bit_cnt, pass_cnt and hit_count;
  - go to SHIFT.
REQ-017 In SHIFT, ser_out SHALL equal shreg[0].
  - Each cycle shreg rotates right by one and bit_cnt increments.
  - The first bit appears in the cycle after start is sampled.
REQ-018 At bit_cnt=WIDTH-1, SHALL act on the pass count:
  - pass_cnt<passes: wrap bit_cnt to 0, increment pass_cnt, stay in SHIFT (no gap between passes);
  - pass_cnt=passes: go to DRAIN.
REQ-019 DRAIN SHALL last exactly DRAIN_CYC cycles with ser_out=0, then go to DONE.
REQ-020 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-021 In IDLE and DONE, ser_out SHALL be 0.
REQ-022 Run length SHALL be WIDTH*(passes+1)+DRAIN_CYC busy cycles, with done in the following cycle.
REQ-023 hit_count SHALL increment by 1 on each cycle with busy=1 and det_in=1.
  - It saturates at 2^CNT_W-1 and never wraps.
  - det_in is ignored when busy=0.
REQ-024 hit_count SHALL hold its value after done until the next accepted start.
REQ-025 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-026 abort=1 in SHIFT or DRAIN SHALL act at that edge:
  - go to IDLE, so busy=0 and ser_out=0 next cycle;
  - no done pulse;
  - hit_count holds the partial count.
REQ-027 abort in IDLE or DONE SHALL have no effect.
REQ-028 If abort and start are both high in IDLE, start SHALL win.
REQ-029 A det_in pulse on the same edge as an abort SHALL still be counted.
REQ-030 Changes on pattern and passes during a run SHALL have no effect.

Reset
REQ-031 On any edge with rst=1, SHALL apply the following, with rst taking priority over start and abort at any point mid-run:
  - state=IDLE;
  - ser_out=0, busy=0, done=0, hit_count=0;
  - shreg, bit_cnt and pass_cnt cleared.
REQ-032 The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-033 SHALL cover a single pass with default parameters:
  - stimulus: pattern=10'b0010101010, passes=0, start at edge 0;
  - ser_out over cycles 1..10 = 0,1,0,1,0,1,0,1,0,0;
  - busy over cycles 1..12, done=1 in cycle 13 only.
REQ-034 SHALL cover repetition and counting:
  - stimulus: passes=2, det_in pulsed at cycles 5, 17 and 31 (31 falls in DRAIN);
  - the pattern repeats back-to-back for 30 cycles;
  - hit_count=3 at done, and it still reads 3 ten cycles later.
REQ-035 SHALL cover saturation:
  - stimulus: passes=15 (162 busy cycles) with det_in held at 1;
  - hit_count=63 at done and never wraps.
REQ-036 SHALL cover abort:
  - stimulus: abort at cycle 4 after det_in pulsed at cycle 4;
  - busy=0 and ser_out=0 from cycle 5, no done pulse, hit_count=1;
  - a start the next cycle is accepted and clears hit_count.
REQ-037 SHALL cover start while busy:
  - stimulus: start pulsed at cycle 6 of a run;
  - ignored, the run completes on the original timing, and exactly one done pulse occurs.
REQ-038 SHALL cover reset mid-run:
  - stimulus: rst=1 at cycle 8;
  - all outputs 0 the next cycle;
  - a start after rst falls gives a full run identical to REQ-033.
